rtype_ibus_encoder: RTL
=======================

# rtype_ibus_encoder

Packs LEGv8 R-type instruction fields (opcode, Rm, shamt, Rn, Rd) into 32-bit `ibus` words and streams them, with sequential word addresses, to the instruction-memory write port. It is the producer of the format the decode-side field extractors consume. Shift amount occupies `ibus[15:10]`. The block is used by the bench and loader path to fill instruction memory before the CPU runs, and it buffers words so the memory side can apply backpressure.

## Interface
- `ADDR_W`, default 32: width of the write address.
- `DEPTH`, default 4: buffer entries; must be a power of 2 and at least 2.
- `ADDR_STEP`, default 4: byte increment per emitted word.
- `clk` in 1: the only clock; everything is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that loads `base_addr` and begins a load run.
- `stop` in 1: one-cycle pulse that ends the run after the buffer drains.
- `base_addr` in `ADDR_W`: first write address, sampled on `start`.
- `in_valid` in 1 / `in_ready` out 1: field-input handshake.
- `in_opcode` in 11, `in_rm` in 5, `in_shamt` in 6, `in_rn` in 5, `in_rd` in 5: instruction fields.
- `out_valid` out 1 / `out_ready` in 1: memory-write handshake.
- `out_addr` out `ADDR_W`: word address of `out_ibus`.
- `out_ibus` out 32: encoded instruction.
- `count` out 16: number of words written in the current run.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse when DRAIN completes.

## Operation
- Encoding: `ibus = {opcode[10:0], rm[4:0], shamt[5:0], rn[4:0], rd[4:0]}`, which places the fields at [31:21], [20:16], [15:10], [9:5] and [4:0]. The encoding is purely combinational ahead of the buffer write.
- The FSM has three states, IDLE, RUN and DRAIN:
  - IDLE → RUN on `start`: `out_addr` ← `base_addr`, `count` ← 0.
  - RUN → DRAIN on `stop`.
  - DRAIN → IDLE when the buffer is empty, with `done` pulsed that cycle.
- `start` is ignored in RUN and DRAIN. `stop` is ignored in IDLE and DRAIN.
- `stop` and `start` together in IDLE: `start` wins.
- `in_ready` = (state == RUN) && !full. A push happens on `in_valid && in_ready`.
- `stop` in the same cycle as an accepted push: the push completes and the word is drained.
- `out_valid` = !empty. The head of the buffer drives `out_ibus`.
- A pop happens on `out_valid && out_ready`. On a pop, `out_addr` += `ADDR_STEP` (wraps mod 2^`ADDR_W`) and `count` += 1 (wraps at 16 bits).
- `out_valid` stays high and `out_ibus`/`out_addr` hold stable until the pop.
- Full buffer: `in_ready` is low even if a pop happens that cycle. There is no fall-through.
- Simultaneous push and pop when not full: occupancy is unchanged and ordering is preserved.
- Any state with the buffer empty: `out_valid` = 0.
- `reset_n` low at any time, including mid-run:
  - the state goes to IDLE and the buffer empties;
  - `out_addr` = 0 and `count` = 0;
  - `in_ready`, `out_valid`, `busy` and `done` are 0;
  - `out_ibus` = 0.
- All outputs reset to 0.

## Timing
- Latency from an accepted input beat to `out_valid` is 1 cycle when the buffer was empty.
- Throughput is 1 word per cycle with `out_ready` held high.
- `busy` rises the cycle after `start` and falls with the `done` cycle's transition.
- `done` is asserted for exactly 1 cycle, registered, in the cycle after the last pop of DRAIN. A `stop` pulse with an empty buffer gives `done` 1 cycle later.
- Reset assertion is asynchronous. Deassertion is synchronized outside this block; the first active edge after deassertion sees IDLE.

## Structure
- Shared package `legv8_pkg` holds:
  - the field LSB/MSB constants (`OPC_MSB`=31, `OPC_LSB`=21, `RM_LSB`=16, `SHAMT_MSB`=15, `SHAMT_LSB`=10, `RN_LSB`=5, `RD_LSB`=0) and the field widths;
  - the FSM state enum `enc_state_t` (IDLE, RUN, DRAIN).
- Decode-side extractors use the same constants.
- Sub-module `ibus_fifo`: synchronous FIFO parameterised by `DEPTH`, with a width of 32, and `full`/`empty` flags derived from an extra pointer bit.

## Test plan
- Reset then `start` with `base_addr`=0x100, push ADD X3,X1,X2 (opcode 0x458, rm 2, shamt 0, rn 1, rd 3) → `out_ibus`=0x8B020023 at `out_addr`=0x100, 1 cycle later.
- Push LSL X5,X6,#12 (opcode 0x69B, rm 0, shamt 12, rn 6, rd 5) → `out_ibus`=0xD36030C5, and `out_ibus[15:10]`=12.
- Hold `out_ready`=0 and push 5 words with `DEPTH`=4 → `in_ready` drops after the 4th push. Release `out_ready` → words come out in order at 0x100, 0x104, 0x108, 0x10C and 0x110, then `count`=5.
- `base_addr`=0xFFFFFFFC, pop 2 words → addresses 0xFFFFFFFC then 0x00000000.
- `stop` with 3 words buffered → `in_ready`=0, 3 pops, then `done` for exactly 1 cycle, then IDLE with `busy`=0.
- Assert `reset_n` low mid-run with 2 words buffered → `out_valid`=0, `count`=0 and `out_addr`=0 immediately. A later `start` produces no stale words.

Source files
------------

// File: rtl/legv8_pkg.sv
// LEGv8 R-type instruction field layout shared by the ibus encoder and the decode-side extractors.
// Also holds the encoder FSM state type and the pack/unpack helpers built on the field constants.
package legv8_pkg;

    localparam int IBUS_W    = 32;

    localparam int OPC_W     = 11;
    localparam int RM_W      = 5;
    localparam int SHAMT_W   = 6;
    localparam int RN_W      = 5;
    localparam int RD_W      = 5;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 21;
    localparam int RM_MSB    = 20;
    localparam int RM_LSB    = 16;
    localparam int SHAMT_MSB = 15;
    localparam int SHAMT_LSB = 10;
    localparam int RN_MSB    = 9;
    localparam int RN_LSB    = 5;
    localparam int RD_MSB    = 4;
    localparam int RD_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } enc_state_t;

    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [RM_W-1:0]    rm;
        logic [SHAMT_W-1:0] shamt;
        logic [RN_W-1:0]    rn;
        logic [RD_W-1:0]    rd;
    } rtype_fields_t;

    function automatic logic [IBUS_W-1:0] encode_rtype(
        input logic [OPC_W-1:0]   opcode,
        input logic [RM_W-1:0]    rm,
        input logic [SHAMT_W-1:0] shamt,
        input logic [RN_W-1:0]    rn,
        input logic [RD_W-1:0]    rd
    );
        logic [IBUS_W-1:0] word;
        word                      = '0;
        word[OPC_MSB:OPC_LSB]     = opcode;
        word[RM_MSB:RM_LSB]       = rm;
        word[SHAMT_MSB:SHAMT_LSB] = shamt;
        word[RN_MSB:RN_LSB]       = rn;
        word[RD_MSB:RD_LSB]       = rd;
        return word;
    endfunction

    // Inverse of encode_rtype, used by the decode side.
    function automatic rtype_fields_t decode_rtype(input logic [IBUS_W-1:0] word);
        rtype_fields_t f;
        f.opcode = word[OPC_MSB:OPC_LSB];
        f.rm     = word[RM_MSB:RM_LSB];
        f.shamt  = word[SHAMT_MSB:SHAMT_LSB];
        f.rn     = word[RN_MSB:RN_LSB];
        f.rd     = word[RD_MSB:RD_LSB];
        return f;
    endfunction

endpackage

// File: rtl/ibus_fifo.sv
// Synchronous word FIFO between the field encoder and the instruction-memory write port.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module ibus_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; stale entries are never visible because the read port is gated by empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
        end
    end

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        level   = wr_ptr_q - rd_ptr_q;
        rd_data = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    end

endmodule

// File: rtl/rtype_ibus_encoder.sv
// Packs LEGv8 R-type fields into ibus words and streams them with sequential addresses
// to the instruction-memory write port, buffering so the memory side can stall.
//
//   state | meaning
//   IDLE  | no run active; waiting for start, base address loaded on start
//   RUN   | accepting field beats and emitting words; stop moves to DRAIN
//   DRAIN | input closed; emitting remaining words, done when buffer empties
module rtype_ibus_encoder
    import legv8_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 4,
    parameter int ADDR_STEP = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPC_W-1:0]   in_opcode,
    input  logic [RM_W-1:0]    in_rm,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [RN_W-1:0]    in_rn,
    input  logic [RD_W-1:0]    in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [IBUS_W-1:0]  out_ibus,
    output logic [15:0]        count,
    output logic               busy,
    output logic               done
);

    localparam int               PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    enc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       count_q, count_d;
    logic              done_q, done_d;

    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [PTR_W:0]    fifo_level, level_nxt;
    logic [IBUS_W-1:0] enc_word;

    assign enc_word = encode_rtype(in_opcode, in_rm, in_shamt, in_rn, in_rd);

    ibus_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IBUS_W),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (enc_word),
        .pop     (pop),
        .rd_data (out_ibus),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)      state_d = RUN;
            RUN:     if (stop)       state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == RUN) && !fifo_full;
        busy      = (state_q != IDLE);
        out_valid = !fifo_empty;
        out_addr  = addr_q;
        count     = count_q;
        done      = done_q;
    end

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // done is precomputed so it is a flop that is high in the empty DRAIN cycle itself.
    always_comb begin
        addr_d    = addr_q;
        count_d   = count_q;
        level_nxt = fifo_level + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        if ((state_q == IDLE) && start) begin
            addr_d  = base_addr;
            count_d = '0;
        end else if (pop) begin
            addr_d  = addr_q + STEP;
            count_d = count_q + 16'd1;
        end
        done_d = (state_d == DRAIN) && (level_nxt == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

endmodule
